crop_bbox_detect: RTL
=====================

// Module: crop_bbox_detect
// PURPOSE
//  Scans the binarised frame stream read from the SDRAM frame buffer (VGA read side) and finds the
//  bounding box of all "dark" (object) pixels in each frame. It also counts those pixels.
//  It sits directly upstream of IMAGE_CROP and supplies its iXSTART/iXEND/iYSTART/iYEND.
//  Replaces the four separate CROP_* scanners with one frame-coherent result.
// PARAMETERS
//  H_ACTIVE   640   active pixels per line (iDVAL beats per line)
//  V_ACTIVE   480   active lines per frame
//  THRESH     512   iDATA < THRESH marks an object (dark) pixel
//  DW         10    iDATA width
// PORTS
//  iCLK      in   1   pixel clock (VGA_CTRL_CLK domain)
//  iRST      in   1   synchronous reset, active-high
//  iDVAL     in   1   pixel beat valid (VGA controller Read request)
//  iDATA     in   DW  pixel value (SD_DATA_R)
//  iSOF      in   1   start-of-frame resync strobe, 1 cycle
//  oXSTART   out  16  leftmost object column of last completed frame
//  oXEND     out  16  rightmost object column
//  oYSTART   out  16  top object row
//  oYEND     out  16  bottom object row
//  oCOUNT    out  20  object pixel count of last completed frame
//  oFOUND    out  1   1 = last completed frame contained >=1 object pixel
//  oVALID    out  1   1-cycle pulse when outputs update
// BEHAVIOUR
//  - Reset (iRST=1 at iCLK edge): x_cnt=y_cnt=0, trackers cleared, all outputs 0, oVALID=0.
//  - Scan counters advance only on iDVAL: x_cnt 0..H_ACTIVE-1, then wraps to 0 and y_cnt++;
//    after (H_ACTIVE-1, V_ACTIVE-1) both wrap to 0. No advance when iDVAL=0 (gaps allowed).
//  - Object pixel: iDVAL=1 and iDATA < THRESH (unsigned). On each object pixel:
//    xmin=min(xmin,x), xmax=max(xmax,x), ymin=min(ymin,y), ymax=max(ymax,y), cnt++.
//  - Tracker clear values: xmin=ymin=16'hFFFF, xmax=ymax=0, cnt=0, hit=0.
//  - Frame end = iDVAL beat at (H_ACTIVE-1, V_ACTIVE-1). That beat's pixel is included.
//    Next cycle: outputs load from trackers, oVALID=1 for exactly one cycle, trackers clear.
//    Latency: last pixel beat at cycle N -> outputs/oVALID valid at cycle N+1.
//  - Empty frame (hit=0): oXSTART=oXEND=oYSTART=oYEND=0, oCOUNT=0, oFOUND=0 (0 box = no crop).
//  - Outputs hold between oVALID pulses; IMAGE_CROP never sees a half-updated box.
//  - iSOF=1: x_cnt,y_cnt=0 and trackers clear, no output update, no oVALID. If iDVAL=1 in the
//    same cycle, that beat is processed as pixel (0,0) of the new frame (iSOF wins over wrap).
//  - iSOF coincident with a frame-end beat: frame is discarded (no oVALID); the beat becomes (0,0).
//  - oCOUNT saturates at 2^20-1 (cannot occur at default sizes).
//  - Reset mid-frame: partial frame discarded, outputs return to 0, scan restarts at (0,0).
//  - Single state machine: SCAN (accumulating) -> PUBLISH (1 cycle, after frame-end beat) -> SCAN.
//    iDVAL beats arriving during PUBLISH are accumulated into the new frame at (0,0) onward.
// TESTING
//  (bench uses H_ACTIVE=8, V_ACTIVE=4, THRESH=512)
//  1 single dark pixel (iDATA=0) at x=3,y=2, rest 1023 -> oVALID pulse; box 3,3,2,2; COUNT=1; FOUND=1
//  2 all pixels 1023 -> oVALID pulse; box 0,0,0,0; COUNT=0; FOUND=0
//  3 dark at (1,0),(6,3),(2,1) with random iDVAL gaps -> box X 1..6, Y 0..3, COUNT=3, 1-cycle lat.
//  4 two back-to-back frames, frame2 dark only at (7,3) -> frame1 result held until frame2 pulse,
//    then box 7,7,3,3; frame2's (0,0) beat during PUBLISH counted correctly
//  5 iSOF asserted at (5,2) mid-frame with dark at (4,1) before it -> no oVALID; next full frame
//    result excludes (4,1); iSOF+iDVAL beat counted as (0,0)
//  6 iRST mid-frame after dark pixels -> all outputs 0 next cycle; following frame reports only
//    its own pixels; iDATA=511 counts as dark, 512 does not

Source files
------------

// File: rtl/crop_bbox_detect_if.sv
// crop_bbox_detect_if: pixel stream in, frame bounding-box result out
interface crop_bbox_detect_if #(parameter int DW = 10);
  logic          iDVAL;
  logic [DW-1:0] iDATA;
  logic          iSOF;
  logic [15:0]   oXSTART;
  logic [15:0]   oXEND;
  logic [15:0]   oYSTART;
  logic [15:0]   oYEND;
  logic [19:0]   oCOUNT;
  logic          oFOUND;
  logic          oVALID;
  modport master (output iDVAL, iDATA, iSOF,
                  input  oXSTART, oXEND, oYSTART, oYEND, oCOUNT, oFOUND, oVALID);
  modport slave  (input  iDVAL, iDATA, iSOF,
                  output oXSTART, oXEND, oYSTART, oYEND, oCOUNT, oFOUND, oVALID);
endinterface

// File: rtl/crop_bbox_detect.sv
// crop_bbox_detect: per-frame bounding box and count of dark pixels in a raster stream
module crop_bbox_detect #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int THRESH   = 512,
  parameter int DW       = 10
) (
  input logic               iCLK,
  input logic               iRST,
  crop_bbox_detect_if.slave bus
);
  typedef enum logic {SCAN, PUBLISH} state_t;
  state_t      r_state, w_state_nxt;
  logic [15:0] r_x, r_y, r_xmin, r_xmax, r_ymin, r_ymax;
  logic [19:0] r_cnt;
  logic        r_hit;
  logic [15:0] r_oxs, r_oxe, r_oys, r_oye;
  logic [19:0] r_ocnt;
  logic        r_ofound;
  logic [15:0] w_x, w_y, w_x_n, w_y_n;
  logic [15:0] w_bxmin, w_bxmax, w_bymin, w_bymax;
  logic [15:0] w_fxmin, w_fxmax, w_fymin, w_fymax;
  logic [19:0] w_bcnt, w_fcnt;
  logic        w_bhit, w_fhit, w_obj, w_xlast, w_ylast, w_eof;
  always_ff @(posedge iCLK)
    r_state <= iRST ? SCAN : w_state_nxt;
  always_comb begin
    w_state_nxt = w_eof ? PUBLISH : SCAN;
  end
  // iSOF forces the current beat to be (0,0) of a fresh frame
  always_comb begin
    w_x     = bus.iSOF ? 16'd0 : r_x;
    w_y     = bus.iSOF ? 16'd0 : r_y;
    w_xlast = w_x == 16'(H_ACTIVE - 1);
    w_ylast = w_y == 16'(V_ACTIVE - 1);
    w_obj   = bus.iDVAL && (int'(bus.iDATA) < THRESH);
    w_eof   = bus.iDVAL && w_xlast && w_ylast && !bus.iSOF;
    w_x_n   = bus.iDVAL ? (w_xlast ? 16'd0 : w_x + 16'd1) : w_x;
    w_y_n   = (bus.iDVAL && w_xlast) ? (w_ylast ? 16'd0 : w_y + 16'd1) : w_y;
    w_bxmin = bus.iSOF ? 16'hFFFF : r_xmin;
    w_bxmax = bus.iSOF ? 16'd0 : r_xmax;
    w_bymin = bus.iSOF ? 16'hFFFF : r_ymin;
    w_bymax = bus.iSOF ? 16'd0 : r_ymax;
    w_bcnt  = bus.iSOF ? 20'd0 : r_cnt;
    w_bhit  = bus.iSOF ? 1'b0 : r_hit;
    w_fxmin = (w_obj && w_x < w_bxmin) ? w_x : w_bxmin;
    w_fxmax = (w_obj && w_x > w_bxmax) ? w_x : w_bxmax;
    w_fymin = (w_obj && w_y < w_bymin) ? w_y : w_bymin;
    w_fymax = (w_obj && w_y > w_bymax) ? w_y : w_bymax;
    w_fcnt  = (w_obj && !(&w_bcnt)) ? w_bcnt + 20'd1 : w_bcnt;
    w_fhit  = w_bhit | w_obj;
  end
  // frame-end beat is folded in and published together; trackers restart empty
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_x      <= '0;
      r_y      <= '0;
      r_xmin   <= 16'hFFFF;
      r_xmax   <= '0;
      r_ymin   <= 16'hFFFF;
      r_ymax   <= '0;
      r_cnt    <= '0;
      r_hit    <= 1'b0;
      r_oxs    <= '0;
      r_oxe    <= '0;
      r_oys    <= '0;
      r_oye    <= '0;
      r_ocnt   <= '0;
      r_ofound <= 1'b0;
    end else begin
      r_x      <= w_x_n;
      r_y      <= w_y_n;
      r_xmin   <= w_eof ? 16'hFFFF : w_fxmin;
      r_xmax   <= w_eof ? 16'd0 : w_fxmax;
      r_ymin   <= w_eof ? 16'hFFFF : w_fymin;
      r_ymax   <= w_eof ? 16'd0 : w_fymax;
      r_cnt    <= w_eof ? 20'd0 : w_fcnt;
      r_hit    <= w_eof ? 1'b0 : w_fhit;
      if (w_eof) begin
        r_oxs    <= w_fhit ? w_fxmin : 16'd0;
        r_oxe    <= w_fhit ? w_fxmax : 16'd0;
        r_oys    <= w_fhit ? w_fymin : 16'd0;
        r_oye    <= w_fhit ? w_fymax : 16'd0;
        r_ocnt   <= w_fcnt;
        r_ofound <= w_fhit;
      end
    end
  end
  assign bus.oXSTART = r_oxs;
  assign bus.oXEND   = r_oxe;
  assign bus.oYSTART = r_oys;
  assign bus.oYEND   = r_oye;
  assign bus.oCOUNT  = r_ocnt;
  assign bus.oFOUND  = r_ofound;
  assign bus.oVALID  = r_state == PUBLISH;
endmodule
